// File: rtl/seg7_pkg.sv
// Shared segment encodings and the BCD decode function for the 7-segment scan driver.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the display pins.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam int unsigned SCAN_DIV_DEFAULT = 1000;
    localparam int unsigned FRAME_LEN        = 2 * SCAN_DIV_DEFAULT;

    function automatic int unsigned frame_len(input int unsigned scan_div);
        return 2 * scan_div;
    endfunction

    // Non-BCD codes (A..F) show a dash so a corrupted counter is visible on the board.
    function automatic logic [6:0] decode_bcd(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high outputs {g,f,e,d,c,b,a}.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = decode_bcd(bcd_i);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit time-multiplexed 7-segment driver with per-frame input snapshot,
// anti-ghosting dead time, leading-zero blanking and selectable pin polarity.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEAD_CYC = 1,
    parameter bit          LZ_BLANK = 1'b1,
    parameter bit          ACT_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic [3:0] bcd_0,
    input  logic [3:0] bcd_1,
    input  logic [1:0] dp_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int unsigned     CntW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dig_q, dig_d;
    logic [3:0]      sh0_q, sh0_d;
    logic [3:0]      sh1_q, sh1_d;
    logic [1:0]      shdp_q, shdp_d;
    logic            tick_q, tick_d;
    logic            en_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= '0;
            dig_q  <= 1'b0;
            sh0_q  <= 4'd0;
            sh1_q  <= 4'd0;
            shdp_q <= 2'b00;
            tick_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            sh0_q  <= sh0_d;
            sh1_q  <= sh1_d;
            shdp_q <= shdp_d;
            tick_q <= tick_d;
            en_q   <= en;
        end
    end

    // While disabled the shadows track the inputs, so the restart frame shows fresh data.
    always_comb begin
        cnt_d  = cnt_q;
        dig_d  = dig_q;
        sh0_d  = sh0_q;
        sh1_d  = sh1_q;
        shdp_d = shdp_q;
        tick_d = 1'b0;
        if (!en) begin
            cnt_d  = '0;
            dig_d  = 1'b0;
            sh0_d  = bcd_0;
            sh1_d  = bcd_1;
            shdp_d = dp_in;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
            dig_d = ~dig_q;
            if (dig_q) begin
                sh0_d  = bcd_0;
                sh1_d  = bcd_1;
                shdp_d = dp_in;
                tick_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    logic in_dead;

    if (DEAD_CYC == 0) begin : g_no_dead
        assign in_dead = 1'b0;
    end else begin : g_dead
        assign in_dead = (cnt_q < CntW'(DEAD_CYC));
    end

    logic [3:0] digit;
    logic [6:0] seg_hi;
    logic       blank_tens;
    logic       lit;

    assign digit = dig_q ? sh1_q : sh0_q;

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd_i (digit),
        .seg_o (seg_hi)
    );

    assign blank_tens = LZ_BLANK && dig_q && (sh1_q == 4'd0);
    assign lit        = en_q && !in_dead && !blank_tens;

    logic [6:0] seg_ah;
    logic       dp_ah;
    logic [1:0] an_ah;

    // Every output depends only on registers, never directly on the inputs.
    always_comb begin
        seg_ah = SEG_OFF;
        dp_ah  = 1'b0;
        an_ah  = 2'b00;
        if (lit) begin
            seg_ah = seg_hi;
            dp_ah  = dig_q ? shdp_q[1] : shdp_q[0];
            an_ah  = {dig_q, ~dig_q};
        end
    end

    always_comb begin
        seg        = seg_ah ^ {7{ACT_LOW}};
        dp         = dp_ah ^ ACT_LOW;
        an         = an_ah ^ {2{ACT_LOW}};
        frame_tick = tick_q;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the two-digit BCD counter. Takes bcd_1 (tens) and bcd_0 (units) and drives a 2-digit time-multiplexed 7-segment display: prescaled digit scan, anti-ghosting dead time, frame-synchronous snapshot of inputs, leading-zero blanking and invalid-code indication. Sits between the counter and the board display pins.

Parameters:
SCAN_DIV, 1000, clock cycles per digit slot (frame = 2*SCAN_DIV cycles); legal range 2..65535.
DEAD_CYC, 1, cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-1.
LZ_BLANK, 1, 1 = blank the tens digit when its snapshot is 0.
ACT_LOW, 1, 1 = seg, dp and an are active-low (common-anode board); 0 = active-high.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-low reset.
en  in  1  display enable.
bcd_0  in  4  units digit from the counter.
bcd_1  in  4  tens digit from the counter.
dp_in  in  2  decimal point request per digit, [0] = units.
seg  out  7  segments {g,f,e,d,c,b,a}, seg[0] = a.
dp  out  1  decimal point of the active digit.
an  out  2  digit select, one-hot when lit; an[0] = units.
frame_tick  out  1  one-cycle pulse in the first cycle of every frame.

Behaviour:
- State: cnt (0..SCAN_DIV-1), dig (0 = units slot, 1 = tens slot), shadows sh0, sh1, shdp, and frame_tick register.
- Reset (RST=0, async): cnt=0, dig=0, sh0=sh1=0, shdp=0, frame_tick=0. All outputs "off" immediately: seg, dp, an all-ones if ACT_LOW, else all-zeros.
- en=0: cnt<=0, dig<=0, frame_tick<=0. Shadows load bcd_0, bcd_1, dp_in on every edge. Outputs off.
- en=1: cnt increments each cycle. At cnt==SCAN_DIV-1 it wraps to 0 and dig toggles.
- Frame snapshot: on the edge with en=1, cnt==SCAN_DIV-1 and dig==1, the shadows load the inputs and frame_tick<=1. Otherwise frame_tick<=0. Inputs that change mid-frame have no effect until the next frame.
- First frame after en rises or after reset release: frame_tick stays 0. This frame displays the shadows as already loaded (0/0 after reset with en held high).
- Slot timing, with p = cnt. For p < DEAD_CYC all anodes are off. For p >= DEAD_CYC, an[dig] is lit with seg = decode(sh[dig]) and dp = shdp[dig].
- Blanking: tens slot with LZ_BLANK=1 and sh1==0 gives an off, seg off, dp off for the whole slot. The units digit is never blanked.
- Decode, active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Codes A..F show dash = 40. ACT_LOW inverts seg, dp and an.
- Outputs are combinational functions of registered state only; there is no input-to-output combinational path. Off-slot outputs must be glitch-free.
- Reset mid-frame: immediate off, restart at cnt=0, dig=0.
- en falling mid-frame: off on the next edge. Restart on the frame-boundary rule above.

Decomposition:
- Package seg7_pkg: seg encoding constants SEG_0..SEG_9, SEG_DASH, SEG_OFF; localparam FRAME_LEN = 2*SCAN_DIV; function decode_bcd.
- One combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-high out), instantiated once on the muxed shadow digit. Polarity inversion stays in the top module.

Test Plan (SCAN_DIV=4, DEAD_CYC=1, ACT_LOW=1 unless noted):
1. RST=0 asserted between clock edges -> same time step: an=2'b11, seg=7'h7F, dp=1, frame_tick=0. These hold until release.
2. en=1, bcd_1=3, bcd_0=7, dp_in=0 -> after first frame_tick, repeating 8-cycle frame: 1 cycle an=11; 3 cycles an=10, seg=7'h78; 1 cycle an=11; 3 cycles an=01, seg=7'h30. frame_tick high exactly every 8th cycle.
3. bcd_1=0, bcd_0=5 -> tens slot an=11 for all 4 cycles; units slot seg=7'h12. With LZ_BLANK=0 the tens slot shows an=01, seg=7'h40.
4. bcd_0 changes 7->2 during the tens slot -> units keeps seg=7'h78 for the rest of the frame. Switches to 7'h24 in the frame after the next frame_tick.
5. bcd_0=4'hC, dp_in=2'b01 -> units slot seg=7'h3F (dash), dp=0. Tens slot dp=1.
6. en dropped at cnt=2 in the tens slot for 3 cycles, then raised -> outputs off on the next edge. Restart with cnt=0, dig=0; first frame_tick 8 cycles after en rises. Repeat with RST pulsed mid-slot -> same restart alignment.
